// File: rtl/raycast_core_arbiter.sv
// raycast_core_arbiter
//   Round-robin arbiter sharing one Wishbone classic read port among N
//   ray-casting cores. One transaction at a time: IDLE -> ISSUE -> RELEASE.
//   A watchdog forces an error if the downstream stays silent too long.
//
// Ports
//   wb_clk, wb_rst       clock, asynchronous active-high reset
//   core_en_i            per-core enable mask (disabled cores never granted)
//   rq_cyc_i, rq_stb_i   per-core Wishbone cyc/stb
//   rq_adr_i             packed core addresses, core k at [k*AW +: AW]
//   rq_dat_o             packed read data, held until that core's next completion
//   rq_ack_o, rq_err_o   per-core one-cycle ack/err pulses (RELEASE only)
//   m_wb_*               shared master port toward the cache/memory
//   grant_o              one-hot grant, zero when idle
//   busy_o               high in ISSUE or RELEASE
module raycast_core_arbiter #(
  parameter int N       = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [N-1:0]    core_en_i,
  input  logic [N-1:0]    rq_cyc_i,
  input  logic [N-1:0]    rq_stb_i,
  input  logic [N*AW-1:0] rq_adr_i,
  output logic [N*DW-1:0] rq_dat_o,
  output logic [N-1:0]    rq_ack_o,
  output logic [N-1:0]    rq_err_o,
  output logic [AW-1:0]   m_wb_adr_o,
  output logic            m_wb_cyc_o,
  output logic            m_wb_stb_o,
  input  logic [DW-1:0]   m_wb_dat_i,
  input  logic            m_wb_ack_i,
  input  logic            m_wb_err_i,
  output logic [N-1:0]    grant_o,
  output logic            busy_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]   LAST_RST = IW'(N - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   gidx;
  logic [TO_W-1:0] tmr;
  logic [N-1:0]    ack_reg;
  logic [N-1:0]    err_reg;

  logic [N-1:0]    req;
  logic            pick_ok;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            timeout_hit;
  logic            abort;
  logic            done;

  assign req = rq_cyc_i & rq_stb_i & core_en_i;

  // Scan upward from the core after the last one served, wrapping.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last) + i) % N);
      if (!pick_ok && req[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (tmr == TO_LAST);
  assign abort       = !rq_cyc_i[gidx];
  assign done        = abort || m_wb_err_i || m_wb_ack_i || timeout_hit;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state      <= IDLE;
      last       <= LAST_RST;
      gidx       <= '0;
      tmr        <= '0;
      ack_reg    <= '0;
      err_reg    <= '0;
      grant_o    <= '0;
      m_wb_adr_o <= '0;
      m_wb_cyc_o <= 1'b0;
      m_wb_stb_o <= 1'b0;
      rq_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            grant_o    <= N'(1) << pick_idx;
            gidx       <= pick_idx;
            m_wb_adr_o <= rq_adr_i[int'(pick_idx)*AW +: AW];
            m_wb_cyc_o <= 1'b1;
            m_wb_stb_o <= 1'b1;
            tmr        <= '0;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (done) begin
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            last       <= gidx;
            state      <= RELEASE;
          end else begin
            tmr <= tmr + 1'b1;
          end
          // An aborting core gets nothing back, even if the slave answers in
          // the same cycle; otherwise err beats ack, and both beat the watchdog.
          if (abort) begin
            ack_reg <= '0;
          end else if (m_wb_err_i) begin
            err_reg <= grant_o;
          end else if (m_wb_ack_i) begin
            ack_reg <= grant_o;
            rq_dat_o[int'(gidx)*DW +: DW] <= m_wb_dat_i;
          end else if (timeout_hit) begin
            err_reg <= grant_o;
          end
        end

        RELEASE: begin
          ack_reg <= '0;
          err_reg <= '0;
          grant_o <= '0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign rq_ack_o = ack_reg & rq_cyc_i;
  assign rq_err_o = err_reg & rq_cyc_i;
  assign busy_o   = (state != IDLE);

endmodule

// File: tb/tb_raycast_core_arbiter.sv
module tb_raycast_core_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            wb_clk = 1'b0;
  logic            wb_rst = 1'b1;
  logic [N-1:0]    core_en = '1;
  logic [N-1:0]    want = '0;
  logic [N-1:0]    cooldown = '0;
  logic [N-1:0]    rq_cyc, rq_stb;
  logic [N*AW-1:0] adr = '0;
  logic [N*DW-1:0] rq_dat;
  logic [N-1:0]    rq_ack, rq_err, grant;
  logic [AW-1:0]   m_adr;
  logic            m_cyc, m_stb, m_ack, m_err, busy;
  logic [DW-1:0]   m_dat;

  // slave model: mode 0 ack, 1 err, 2 err+ack, 3 silent
  logic [1:0]      slv_mode = 2'd0;
  logic [15:0]     slv_wait = 16'd0;
  logic [DW-1:0]   slv_dat  = '0;
  logic [15:0]     scnt = '0;

  typedef struct {
    int          core;
    bit          is_err;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_dat [N];
  int            errors = 0;
  int            checks = 0;

  always #5 wb_clk = ~wb_clk;

  assign rq_cyc = want;
  assign rq_stb = want & ~cooldown;
  assign m_dat  = slv_dat ^ m_adr;
  assign m_ack  = m_cyc & m_stb & (scnt == slv_wait) & ((slv_mode == 2'd0) | (slv_mode == 2'd2));
  assign m_err  = m_cyc & m_stb & (scnt == slv_wait) & ((slv_mode == 2'd1) | (slv_mode == 2'd2));

  always @(posedge wb_clk) begin
    scnt     <= (m_cyc & m_stb) ? scnt + 16'd1 : 16'd0;
    cooldown <= rq_ack | rq_err;
  end

  raycast_core_arbiter #(
    .N(N), .AW(AW), .DW(DW), .TO_W(8), .TIMEOUT(200)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .core_en_i(core_en),
    .rq_cyc_i(rq_cyc), .rq_stb_i(rq_stb), .rq_adr_i(adr),
    .rq_dat_o(rq_dat), .rq_ack_o(rq_ack), .rq_err_o(rq_err),
    .m_wb_adr_o(m_adr), .m_wb_cyc_o(m_cyc), .m_wb_stb_o(m_stb),
    .m_wb_dat_i(m_dat), .m_wb_ack_i(m_ack), .m_wb_err_i(m_err),
    .grant_o(grant), .busy_o(busy)
  );

  task automatic set_adr(input int k, input logic [AW-1:0] a);
    adr[k*AW +: AW] = a;
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    sb.delete();
    for (int k = 0; k < N; k++) model_dat[k] = '0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin errors++; $display("FAIL reset_cycstb: got %b%b want 00", m_cyc, m_stb); end
    checks++; if (m_adr !== '0) begin errors++; $display("FAIL reset_adr: got %h want 0", m_adr); end
    checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_grant_busy: got %b/%b want 0000/0", grant, busy); end
    checks++; if (rq_ack !== '0 || rq_err !== '0) begin errors++; $display("FAIL reset_ackerr: got %b/%b want 0", rq_ack, rq_err); end
    checks++; if (rq_dat !== '0) begin errors++; $display("FAIL reset_dat: got %h want 0", rq_dat); end
    @(negedge wb_clk);
    wb_rst = 1'b0;
    for (int k = 0; k < N; k++) model_dat[k] = '0;
  endtask

  task automatic test_single();
    exp_t e;
    slv_mode = 2'd0; slv_wait = 16'd0;
    slv_dat = 32'hDEADBEEF ^ 32'h40;
    set_adr(2, 32'h0000_0040);
    @(negedge wb_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b want 0", busy); end
    want = 4'b0100;
    model_dat[2] = 32'hDEADBEEF;
    sb.push_back('{core: 2, is_err: 1'b0, dat: 32'hDEADBEEF});
    @(negedge wb_clk);
    checks++; if (m_cyc !== 1'b1 || m_stb !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_issue: cyc/stb/busy got %b%b%b want 111", m_cyc, m_stb, busy); end
    checks++; if (m_adr !== 32'h40) begin errors++; $display("FAIL single_adr: got %h want 00000040", m_adr); end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
    @(negedge wb_clk);
    checks++; if (rq_ack !== 4'b0100 || rq_err !== 4'b0000) begin errors++; $display("FAIL single_ack: ack/err got %b/%b want 0100/0000", rq_ack, rq_err); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (rq_dat[e.core*DW +: DW] !== e.dat) begin errors++; $display("FAIL single_dat: got %h want %h", rq_dat[e.core*DW +: DW], e.dat); end
    end
    checks++; if (m_cyc !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_release: cyc/busy got %b/%b want 0/1", m_cyc, busy); end
    want = '0;
    @(negedge wb_clk);
    checks++; if (busy !== 1'b0 || rq_ack !== '0 || grant !== '0) begin errors++; $display("FAIL single_back_idle: busy/ack/grant got %b/%b/%b want 0/0000/0000", busy, rq_ack, grant); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   n = 0;
    int   t_ack [6];
    do_reset();
    slv_mode = 2'd0; slv_wait = 16'd0; slv_dat = 32'h5A5A_0000;
    for (int k = 0; k < N; k++) set_adr(k, 32'h1000 + 32'(k) * 32'h10);
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{core: i % N, is_err: 1'b0, dat: slv_dat ^ (32'h1000 + 32'(i % N) * 32'h10)});
      model_dat[i % N] = slv_dat ^ (32'h1000 + 32'(i % N) * 32'h10);
    end
    @(negedge wb_clk);
    want = 4'b1111;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge wb_clk);
      if ((rq_ack | rq_err) != '0) begin
        e = sb.pop_front();
        checks++; if (rq_ack !== (4'b0001 << e.core) || rq_err !== '0) begin errors++; $display("FAIL rr_order[%0d]: ack/err got %b/%b want core %0d", n, rq_ack, rq_err, e.core); end
        checks++; if (rq_dat[e.core*DW +: DW] !== e.dat) begin errors++; $display("FAIL rr_dat[%0d]: got %h want %h", n, rq_dat[e.core*DW +: DW], e.dat); end
        t_ack[n] = c;
        n++;
        if (n == 6) want = '0;
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL rr_count: got %0d acks want 6", n); want = '0; end
    else begin
      checks++; if (t_ack[4] - t_ack[0] != 12 || t_ack[5] - t_ack[1] != 12) begin errors++; $display("FAIL rr_period: got %0d/%0d cycles want 12/12", t_ack[4] - t_ack[0], t_ack[5] - t_ack[1]); end
    end
    repeat (3) @(negedge wb_clk);
  endtask

  task automatic test_mask_fairness();
    exp_t e;
    int   n = 0;
    int   order [4] = '{3, 1, 3, 0};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{core: order[i], is_err: 1'b0, dat: slv_dat ^ (32'h1000 + 32'(order[i]) * 32'h10)});
    end
    core_en = 4'b1010;
    want = 4'b1111;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge wb_clk);
      if ((rq_ack | rq_err) != '0) begin
        e = sb.pop_front();
        checks++; if (rq_ack !== (4'b0001 << e.core) || rq_err !== '0) begin errors++; $display("FAIL mask_order[%0d]: ack/err got %b/%b want core %0d", n, rq_ack, rq_err, e.core); end
        checks++; if (rq_dat[e.core*DW +: DW] !== e.dat) begin errors++; $display("FAIL mask_dat[%0d]: got %h want %h", n, rq_dat[e.core*DW +: DW], e.dat); end
        model_dat[e.core] = e.dat;
        n++;
        if (n == 3) begin
          core_en = 4'b1111;
          want = 4'b1001;
          sb.push_back('{core: 0, is_err: 1'b0, dat: slv_dat ^ 32'h1000});
        end else if (n == 4) begin
          want = '0;
        end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL mask_count: got %0d acks want 4", n); want = '0; end
    repeat (3) @(negedge wb_clk);
  endtask

  task automatic test_errors();
    exp_t e;
    int   got = 0;
    int   cyc_cnt = 0;
    slv_mode = 2'd2; slv_wait = 16'd0;
    set_adr(1, 32'h80);
    sb.push_back('{core: 1, is_err: 1'b1, dat: model_dat[1]});
    want = 4'b0010;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge wb_clk);
      if ((rq_ack | rq_err) != '0) begin
        e = sb.pop_front();
        got = 1;
        checks++; if (rq_err !== 4'b0010 || rq_ack !== 4'b0000) begin errors++; $display("FAIL errack_pulse: err/ack got %b/%b want 0010/0000", rq_err, rq_ack); end
        checks++; if (rq_dat[e.core*DW +: DW] !== e.dat) begin errors++; $display("FAIL errack_dat: got %h want %h", rq_dat[e.core*DW +: DW], e.dat); end
        want = '0;
      end
    end
    checks++; if (got == 0) begin errors++; $display("FAIL errack_timeout: no response want err"); want = '0; end
    repeat (2) @(negedge wb_clk);

    slv_mode = 2'd3;
    got = 0;
    sb.push_back('{core: 0, is_err: 1'b1, dat: model_dat[0]});
    want = 4'b0001;
    for (int c = 0; c < 400 && got == 0; c++) begin
      @(negedge wb_clk);
      if (m_cyc) cyc_cnt++;
      if ((rq_ack | rq_err) != '0) begin
        e = sb.pop_front();
        got = 1;
        checks++; if (rq_err !== 4'b0001 || rq_ack !== 4'b0000) begin errors++; $display("FAIL wdog_pulse: err/ack got %b/%b want 0001/0000", rq_err, rq_ack); end
        checks++; if (cyc_cnt != 200) begin errors++; $display("FAIL wdog_cycles: got %0d want 200", cyc_cnt); end
        checks++; if (rq_dat[e.core*DW +: DW] !== e.dat) begin errors++; $display("FAIL wdog_dat: got %h want %h", rq_dat[e.core*DW +: DW], e.dat); end
        want = '0;
      end
    end
    checks++; if (got == 0) begin errors++; $display("FAIL wdog_timeout: no err after %0d cycles", cyc_cnt); want = '0; end
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic test_abort();
    int seen = 0;
    int found = 0;
    slv_mode = 2'd3;
    want = 4'b0010;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge wb_clk);
      if (m_cyc) found = 1;
    end
    checks++; if (found == 0) begin errors++; $display("FAIL abort_start: cyc got 0 want 1"); end
    repeat (2) @(negedge wb_clk);
    want = '0;
    @(negedge wb_clk);
    if ((rq_ack | rq_err) != '0) seen = 1;
    checks++; if (m_cyc !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_release: cyc/busy got %b/%b want 0/1", m_cyc, busy); end
    @(negedge wb_clk);
    if ((rq_ack | rq_err) != '0) seen = 1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b want 0", busy); end
    repeat (3) begin
      @(negedge wb_clk);
      if ((rq_ack | rq_err) != '0) seen = 1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_noresp: got response want none"); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   got = 0;
    int   found = 0;
    slv_mode = 2'd3;
    want = 4'b0100;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge wb_clk);
      if (m_cyc) found = 1;
    end
    #2 wb_rst = 1'b1;
    #1;
    checks++; if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin errors++; $display("FAIL rstmid_cyc: cyc/stb got %b%b want 00", m_cyc, m_stb); end
    checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_grant: grant/busy got %b/%b want 0000/0", grant, busy); end
    want = 4'b1111;
    slv_mode = 2'd0;
    sb.delete();
    for (int k = 0; k < N; k++) model_dat[k] = '0;
    model_dat[0] = slv_dat ^ adr[0 +: AW];
    sb.push_back('{core: 0, is_err: 1'b0, dat: slv_dat ^ adr[0 +: AW]});
    @(negedge wb_clk);
    wb_rst = 1'b0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge wb_clk);
      if ((rq_ack | rq_err) != '0) begin
        e = sb.pop_front();
        got = 1;
        checks++; if (rq_ack !== 4'b0001 || rq_err !== '0) begin errors++; $display("FAIL rstmid_first: ack/err got %b/%b want 0001/0000", rq_ack, rq_err); end
        checks++; if (rq_dat[e.core*DW +: DW] !== e.dat) begin errors++; $display("FAIL rstmid_dat: got %h want %h", rq_dat[e.core*DW +: DW], e.dat); end
        checks++; if (rq_dat[2*DW +: DW] !== model_dat[2]) begin errors++; $display("FAIL rstmid_clear: got %h want %h", rq_dat[2*DW +: DW], model_dat[2]); end
        want = '0;
      end
    end
    checks++; if (got == 0) begin errors++; $display("FAIL rstmid_timeout: no ack want core 0"); want = '0; end
    repeat (2) @(negedge wb_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask_fairness();
    test_errors();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raycast_core_arbiter.md
Name: raycast_core_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone classic read port among N ray-casting cores. The shared port feeds the raycast cache/memory master.
- Serialises core read requests one transaction at a time and returns data and ack/err to the granted core.
- Enforces a watchdog timeout so that a stalled downstream cannot hang a core.

Parameters:
- N, 4, number of requesting cores (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TO_W, 8, width of the timeout counter.
- TIMEOUT, 200, max cycles in ISSUE before forced error; 0 disables the watchdog; must be < 2^TO_W.

Ports:
- wb_clk  in  1  clock; all logic on the rising edge.
- wb_rst  in  1  reset; asynchronous, active-high.
- core_en_i  in  N  per-core enable mask; a disabled core is never granted.
- rq_cyc_i  in  N  per-core Wishbone cyc.
- rq_stb_i  in  N  per-core Wishbone stb.
- rq_adr_i  in  N*AW  packed core addresses; core k occupies bits [k*AW +: AW].
- rq_dat_o  out  N*DW  packed read data per core; holds its value until that core's next completion.
- rq_ack_o  out  N  per-core ack, one-cycle pulse.
- rq_err_o  out  N  per-core err, one-cycle pulse.
- m_wb_adr_o  out  AW  shared-port address.
- m_wb_cyc_o  out  1  shared-port cyc.
- m_wb_stb_o  out  1  shared-port stb.
- m_wb_dat_i  in  DW  shared-port read data.
- m_wb_ack_i  in  1  shared-port ack.
- m_wb_err_i  in  1  shared-port err.
- grant_o  out  N  one-hot current grant; zero when idle.
- busy_o  out  1  high in ISSUE or RELEASE.

Behaviour:
- Reset (async): all outputs 0, including rq_dat_o. State = IDLE. last = N-1, so core 0 has first priority. Timeout counter = 0.
- Reset mid-transaction: m_wb_cyc_o and m_wb_stb_o drop immediately; no ack or err is issued for the lost transaction.
- Request vector: req[k] = rq_cyc_i[k] & rq_stb_i[k] & core_en_i[k].

IDLE:
- If req != 0, select the first set bit scanning upward from (last+1) mod N, wrapping.
- Register the one-hot grant and latch that core's address into m_wb_adr_o.
- Clear the timeout counter and go to ISSUE.
- m_wb_cyc_o and m_wb_stb_o are registered: request sampled at edge t gives cyc/stb high from edge t+1.

ISSUE:
- m_wb_cyc_o = m_wb_stb_o = 1; the address is held stable; the counter increments each cycle.
- On m_wb_ack_i: capture m_wb_dat_i into the granted core's rq_dat_o slice, set the granted ack register, go to RELEASE.
- On m_wb_err_i (wins over a simultaneous ack): rq_dat_o is unchanged, set the granted err register, go to RELEASE.
- Watchdog: TIMEOUT != 0 and counter == TIMEOUT-1 with no ack/err → set err register, go to RELEASE. An ack or err arriving in that same cycle takes precedence over the timeout.
- Abort: the granted core drops rq_cyc_i → no ack/err to it, go to RELEASE.
- A change of core_en_i during ISSUE does not abort the transaction in flight.
- On every exit from ISSUE: cyc/stb go low at the next edge and last = granted index.

RELEASE (exactly one cycle):
- cyc/stb are low.
- rq_ack_o[k] = ack_reg[k] & rq_cyc_i[k]; rq_err_o[k] = err_reg[k] & rq_cyc_i[k].
- grant_o stays valid; it clears on return to IDLE.
- Next state is always IDLE. The core samples ack at the end of RELEASE and drops stb, so its stb is low in the following IDLE cycle.

Throughput and outputs:
- Minimum 3 cycles per transaction: IDLE, ISSUE with zero-wait ack, RELEASE.
- At most one of rq_ack_o/rq_err_o is set at a time, and never for more than one core.
- rq_ack_o and rq_err_o are never asserted outside RELEASE.

Fairness:
- With all N cores continuously requesting, grants rotate 0,1,..,N-1,0...
- No core waits more than N-1 other transactions.

Test Plan:
- Single request: reset; core 2 requests adr 0x0000_0040; slave acks the 1st ISSUE cycle with 0xDEAD_BEEF → m_wb_adr_o = 0x40; rq_dat_o slice 2 = 0xDEADBEEF; rq_ack_o = 4'b0100 for 1 cycle; exactly 3 cycles from IDLE to the next IDLE.
- Round robin: cores 0–3 request continuously, zero-wait slave → grant order 0,1,2,3,0,1; each core gets one ack per 12 cycles.
- Mask and fairness: core_en_i = 4'b1010, all cores requesting → only cores 1 and 3 are granted, alternating. Next case: after core 3's grant, cores 0 and 3 requesting with all enabled → core 0 is granted.
- Errors: slave asserts err+ack together → rq_err_o pulses, no ack, rq_dat_o unchanged. Next case: TIMEOUT = 200, slave silent → m_wb_cyc_o drops after exactly 200 ISSUE cycles; rq_err_o pulses for the granted core.
- Abort and reset: core 1 drops rq_cyc_i in the 3rd wait cycle → no ack/err, RELEASE then IDLE. Next case: wb_rst asserted mid-ISSUE → m_wb_cyc_o = 0 without waiting for a clock edge; after release, core 0 is granted first.
